// File: rtl/seq_pattern_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seq_pattern_gen
// Purpose  : Serial MSB-first pattern transmitter with repeat count, fixed
//            inter-pass idle gap and valid/ready handshake on the bit output.
// Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_gen #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] repeats,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             last_bit,
    output logic             busy,
    output logic             done
);

    localparam int c_IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int c_GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [LEN_W-1:0]   c_PAT_W_L  = LEN_W'(PAT_W);
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = (GAP > 0) ? c_GAP_W'(GAP - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAPW = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic [PAT_W-1:0]     r_pat;
    logic [c_IDX_W-1:0]   r_len_m1;
    logic [c_IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]     r_pass;
    logic [c_GAP_W-1:0]   r_gap;

    state_t               w_nxt_state;
    logic [PAT_W-1:0]     w_nxt_pat;
    logic [c_IDX_W-1:0]   w_nxt_len_m1;
    logic [c_IDX_W-1:0]   w_nxt_idx;
    logic [CNT_W-1:0]     w_nxt_pass;
    logic [c_GAP_W-1:0]   w_nxt_gap;
    logic [LEN_W-1:0]     w_len_c;
    logic                 w_nxt_send;

    assign w_len_c    = (len > c_PAT_W_L) ? c_PAT_W_L : len;
    assign w_nxt_send = (w_nxt_state == S_SEND);

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_pat    = r_pat;
        w_nxt_len_m1 = r_len_m1;
        w_nxt_idx    = r_idx;
        w_nxt_pass   = r_pass;
        w_nxt_gap    = r_gap;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nxt_pat    = pattern;
                    w_nxt_len_m1 = c_IDX_W'(w_len_c - 1'b1);
                    w_nxt_idx    = c_IDX_W'(w_len_c - 1'b1);
                    w_nxt_pass   = repeats;
                    w_nxt_state  = (w_len_c == '0) ? S_DONE : S_SEND;
                end
            end
            S_SEND: begin
                // bit_valid is always high in SEND, so bit_ready alone marks a transfer
                if (bit_ready) begin
                    if (r_idx != '0) begin
                        w_nxt_idx = r_idx - 1'b1;
                    end else if (r_pass != '0) begin
                        w_nxt_pass = r_pass - 1'b1;
                        w_nxt_idx  = r_len_m1;
                        if (GAP > 0) begin
                            w_nxt_state = S_GAPW;
                            w_nxt_gap   = c_GAP_LOAD;
                        end
                    end else begin
                        w_nxt_state = S_DONE;
                    end
                end
            end
            S_GAPW: begin
                if (r_gap == '0) begin
                    w_nxt_state = S_SEND;
                end else begin
                    w_nxt_gap = r_gap - 1'b1;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they align with the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pat     <= '0;
            r_len_m1  <= '0;
            r_idx     <= '0;
            r_pass    <= '0;
            r_gap     <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            last_bit  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_pat     <= w_nxt_pat;
            r_len_m1  <= w_nxt_len_m1;
            r_idx     <= w_nxt_idx;
            r_pass    <= w_nxt_pass;
            r_gap     <= w_nxt_gap;
            bit_out   <= w_nxt_send & w_nxt_pat[w_nxt_idx];
            bit_valid <= w_nxt_send;
            last_bit  <= w_nxt_send && (w_nxt_idx == '0) && (w_nxt_pass == '0);
            busy      <= w_nxt_send || (w_nxt_state == S_GAPW);
            done      <= (w_nxt_state == S_DONE);
        end
    end

endmodule
`default_nettype wire
